// File: rtl/autocat_pkg.sv
// autocat_pkg: shared types and width helpers for the autocat way-partition advisor.
//   state_t   - evaluation engine states (IDLE, LOAD, SELECT, DONE)
//   ch_w_f    - channel-id width, max(1, clog2(channels))
//   sum_w_f   - width of totals/sums so N saturated counters never overflow
//   CH_W/SUM_W - widths for the default configuration (4 channels, 16 ways, 32-bit)
package autocat_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SELECT, DONE} state_t;

  function automatic int ch_w_f(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int sum_w_f(input int cw, input int n);
    return cw + $clog2(n);
  endfunction

  localparam int CH_W  = ch_w_f(4);
  localparam int SUM_W = sum_w_f(32, 16);

endpackage

// File: rtl/autocat_argmax.sv
// autocat_argmax: combinational masked argmax.
//   vals_in   - N values of W bits
//   elig_in   - per-entry eligibility
//   idx_out   - index of the largest eligible value, lowest index on ties
//   found_out - at least one entry was eligible
module autocat_argmax #(
  parameter int N  = 16,
  parameter int W  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0][W-1:0] vals_in,
  input  logic [N-1:0]        elig_in,
  output logic [IW-1:0]       idx_out,
  output logic                found_out
);

  logic [W-1:0] best;

  // Linear scan; strict '>' keeps the earliest entry among equals.
  always_comb begin
    idx_out   = '0;
    found_out = 1'b0;
    best      = '0;
    for (int i = 0; i < N; i++) begin
      if (elig_in[i] && (!found_out || vals_in[i] > best)) begin
        found_out = 1'b1;
        best      = vals_in[i];
        idx_out   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/autocat_mc.sv
// autocat_mc: multi-channel way-partition advisor.
// Each channel counts accesses and per-way hits over an epoch of 2^p accesses.
// At epoch end a shared serial engine picks the fewest top-hit ways whose
// hit sum comes within allowed_gap_in of the channel total and publishes a
// low-aligned waymask of that many ways.
//   clk_in, reset_n_in       - clock, async active-low reset
//   enable_in                - gates counting and new evaluations
//   epoch_power_in           - p (clamped to COUNTER_WIDTH-1)
//   allowed_gap_in           - tolerated hit shortfall
//   access_valid_in/_channel_in/hit_vec_in - one access per valid cycle
//   waymask_out              - per-channel masks, channel c at [c*N +: N]
//   update_valid_out/_channel_out - one-cycle pulse per mask rewrite
//   overrun_out              - sticky: epoch ended while still pending
//   busy_out                 - engine not idle
module autocat_mc
  import autocat_pkg::*;
#(
  parameter int CACHE_ASSOCIATIVITY = 16,
  parameter int NUM_CHANNELS        = 4,
  parameter int COUNTER_WIDTH       = 32,
  localparam int N   = CACHE_ASSOCIATIVITY,
  localparam int CW  = COUNTER_WIDTH,
  localparam int CHW = ch_w_f(NUM_CHANNELS),
  localparam int SW  = sum_w_f(COUNTER_WIDTH, CACHE_ASSOCIATIVITY),
  localparam int SW1 = SW + 1,
  localparam int KW  = $clog2(CACHE_ASSOCIATIVITY + 1),
  localparam int IW  = $clog2(CACHE_ASSOCIATIVITY)
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic                      enable_in,
  input  logic [5:0]                epoch_power_in,
  input  logic [CW-1:0]             allowed_gap_in,
  input  logic                      access_valid_in,
  input  logic [CHW-1:0]            access_channel_in,
  input  logic [N-1:0]              hit_vec_in,
  output logic [NUM_CHANNELS*N-1:0] waymask_out,
  output logic                      update_valid_out,
  output logic [CHW-1:0]            update_channel_out,
  output logic [NUM_CHANNELS-1:0]   overrun_out,
  output logic                      busy_out
);

  state_t state, state_n;

  logic [NUM_CHANNELS-1:0][N-1:0][CW-1:0] hcnt;
  logic [NUM_CHANNELS-1:0][CW-1:0]        acnt;
  logic [NUM_CHANNELS-1:0]                pending, overrun, acc_hit, ld_hit, wrap;
  logic [NUM_CHANNELS-1:0][N-1:0]         mask_q;

  logic [N-1:0][CW-1:0] snap;
  logic [SW-1:0]        total, sum_q, sum_nxt, ld_total;
  logic [SW1-1:0]       reach;
  logic [N-1:0]         picked, kmask;
  logic [KW-1:0]        k;
  logic [CHW-1:0]       ch, first_pend;
  logic                 any_pend, sel_done, am_found, start;
  logic [IW-1:0]        am_idx;
  logic [5:0]           p_eff;
  logic [CW-1:0]        limit;

  assign p_eff = (epoch_power_in > 6'(CW-1)) ? 6'(CW-1) : epoch_power_in;
  assign limit = CW'(1) << p_eff;

  always_comb begin
    acc_hit = '0;
    ld_hit  = '0;
    wrap    = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      acc_hit[c] = enable_in && access_valid_in && (int'(access_channel_in) == c);
      ld_hit[c]  = (state == LOAD) && (int'(ch) == c);
      wrap[c]    = acc_hit[c] && (acnt[c] + CW'(1) == limit);
    end
  end

  // Counter bank. A LOAD-cycle access to the loading channel starts the new
  // epoch, so its hits replace the cleared counts rather than being lost.
  // A wrap in that same cycle re-arms pending without flagging overrun,
  // since the previous epoch is being served right now.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      hcnt    <= '0;
      acnt    <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (acc_hit[c]) acnt[c] <= wrap[c] ? '0 : acnt[c] + CW'(1);
        pending[c] <= wrap[c] | (pending[c] & ~ld_hit[c]);
        if (wrap[c] && pending[c] && !ld_hit[c]) overrun[c] <= 1'b1;
        for (int w = 0; w < N; w++) begin
          if (ld_hit[c])
            hcnt[c][w] <= (acc_hit[c] && hit_vec_in[w]) ? CW'(1) : '0;
          else if (acc_hit[c] && hit_vec_in[w] && hcnt[c][w] != '1)
            hcnt[c][w] <= hcnt[c][w] + CW'(1);
        end
      end
    end
  end

  // Lowest-index pending channel wins.
  always_comb begin
    first_pend = '0;
    any_pend   = |pending;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--)
      if (pending[c]) first_pend = CHW'(c);
  end

  always_comb begin
    ld_total = '0;
    for (int w = 0; w < N; w++) ld_total = ld_total + SW'(hcnt[ch][w]);
  end

  autocat_argmax #(.N(N), .W(CW), .IW(IW)) u_argmax (
    .vals_in   (snap),
    .elig_in   (~picked),
    .idx_out   (am_idx),
    .found_out (am_found)
  );

  // One spare bit so sum + gap cannot wrap in the compare.
  assign sum_nxt  = sum_q + SW'(snap[am_idx]);
  assign reach    = SW1'(sum_nxt) + SW1'(allowed_gap_in);
  assign sel_done = (reach >= SW1'(total)) || (k == KW'(N - 1));
  assign start    = enable_in && any_pend;

  always_comb begin
    kmask = '0;
    for (int w = 0; w < N; w++) kmask[w] = (KW'(w) < k);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    state_n = SELECT;
      SELECT:  if (sel_done) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ch                 <= '0;
      snap               <= '0;
      total              <= '0;
      sum_q              <= '0;
      k                  <= '0;
      picked             <= '0;
      mask_q             <= '1;
      update_valid_out   <= 1'b0;
      update_channel_out <= '0;
    end else begin
      update_valid_out <= 1'b0;
      case (state)
        IDLE: if (start) ch <= first_pend;
        LOAD: begin
          snap   <= hcnt[ch];
          total  <= ld_total;
          sum_q  <= '0;
          k      <= '0;
          picked <= '0;
        end
        SELECT: if (am_found) begin
          sum_q          <= sum_nxt;
          picked[am_idx] <= 1'b1;
          k              <= k + KW'(1);
        end
        DONE: begin
          mask_q[ch]         <= kmask;
          update_valid_out   <= 1'b1;
          update_channel_out <= ch;
        end
        default: ;
      endcase
    end
  end

  assign waymask_out = mask_q;
  assign overrun_out = overrun;
  assign busy_out    = (state != IDLE);

endmodule

// File: doc/autocat_mc.md
# autocat_mc

Multi-channel successor to the single-channel way-partition advisor in the LLC control path.
- Per channel, counts per-way hits over an epoch of 2^p accesses.
- At each epoch end, a shared serial engine finds the fewest ways whose top hit counts come within a programmable gap of the channel's total hits.
- Publishes a per-channel suggested waymask and a one-cycle update strobe to the partition control registers.

## Interface
- CACHE_ASSOCIATIVITY, 16: ways N; any value ≥2.
- NUM_CHANNELS, 4: independently tracked channels (DSIDs), ≥1.
- COUNTER_WIDTH, 32: hit/access counter width.
- clk_in  in  1  single clock, all logic rising-edge.
- reset_n_in  in  1  asynchronous, active-low reset.
- enable_in  in  1  when 0, no counting and no new evaluations; an in-flight evaluation completes.
- epoch_power_in  in  6  p; epoch = 2^p accesses; values > COUNTER_WIDTH-1 clamp to COUNTER_WIDTH-1.
- allowed_gap_in  in  COUNTER_WIDTH  tolerated hit shortfall vs. total.
- access_valid_in  in  1  one access per high cycle.
- access_channel_in  in  max(1,clog2(NUM_CHANNELS))  channel of access; ids ≥ NUM_CHANNELS ignored.
- hit_vec_in  in  N  per-way hit, sampled only with access_valid_in.
- waymask_out  out  NUM_CHANNELS*N  channel c at [c*N +: N]; reset all ones.
- update_valid_out  out  1  one-cycle pulse when a channel's mask is rewritten; reset 0.
- update_channel_out  out  CH_W  channel of the pulse; reset 0.
- overrun_out  out  NUM_CHANNELS  sticky: epoch ended while already pending; reset 0, cleared only by reset.
- busy_out  out  1  engine not IDLE; reset 0.

## Operation
- Counter bank, per channel: access counter A[c] and N hit counters H[c][w].
- Valid access to channel c with enable_in=1: A+1, and H[c][w]+1 for each set hit bit.
- Hit counters saturate at all-ones.
- When the increment makes A = 2^p: A←0 and pending[c]←1.
  - If pending[c] was already 1, overrun[c]←1 and counts keep accumulating into the same unserved epoch.
- Engine FSM:
  - IDLE: if enable_in and any pending, select the lowest-index pending channel and go LOAD.
  - LOAD: copy H[ch][*] into snapshot S[*], clear H[ch][*] and pending[ch], and register total T = ΣS. Go SELECT with sum=0, k=0, picked=0.
  - SELECT, one step per cycle:
    - m = argmax of S over unpicked ways; ties go to the lowest index.
    - sum += S[m]; set picked[m]; k += 1.
    - If sum + allowed_gap_in ≥ T, or k = N, go DONE.
  - DONE: waymask[ch] ← k low bits set (ways 0..k-1); update_valid_out=1 and update_channel_out=ch next cycle; go IDLE.
- Arithmetic: sum, T and the comparison use COUNTER_WIDTH+clog2(N) bits, zero-extended; no overflow.
- T = 0 gives k=1 (mask 0x…0001).
- An access to ch in the LOAD cycle starts the new epoch: H becomes its hit bits, not 0, and A updates normally.
- Async reset mid-evaluation: FSM→IDLE, all counters, pending and snapshot cleared, masks all ones.

## Timing
- The access reaching the limit at cycle T sets pending visible at T+1.
- IDLE→LOAD at T+2; SELECT occupies T+3..T+2+k; DONE at T+3+k.
- New mask and update_valid_out are visible at T+4+k.
- Engine throughput is one channel per k+3 cycles; the next pending channel enters LOAD no earlier than two cycles after DONE.
- waymask_out changes only in the cycle update_valid_out is high.

## Structure
- Package autocat_pkg holds the state enum (IDLE, LOAD, SELECT, DONE) and the clog2-derived width constants CH_W and SUM_W.
- Sub-module autocat_argmax: combinational masked argmax over N×COUNTER_WIDTH with lowest-index tie-break. It is shared by SELECT and verified standalone.

## Test plan
- N=16, 1 channel, p=4, 16 accesses all hitting way 0, gap 0 -> mask 0x0001 and update pulse 5 cycles after the 16th access.
- p=4, hits spread 4 each on ways 3,7,9,12, gap 0 -> k=4, mask 0x000F; with gap 4 -> k=3, mask 0x0007.
- Channels 0 and 2 reach limit in the same cycle -> channel 0 updated first, then channel 2. Overrun is not set.
- Channel 1 reaches its limit twice while the engine is busy on channel 0 -> overrun_out[1]=1; channel 1 evaluated once using the merged counts.
- Zero-hit epoch (p=3, 8 misses) -> mask 0x0001. Assert reset_n_in low mid-SELECT -> masks 0xFFFF, busy_out 0 immediately.
- Access to channel ch with hit way 5 during its LOAD cycle -> snapshot excludes it; next epoch starts with H[ch][5]=1.
